// File: rtl/pp_accum.sv
// Radix-16 partial-product accumulator.
// Sums NUM_PP partial products, each weighted by 16^k, into a 2*WIDTH-bit
// product. There is a valid/ready handshake on the partial-product input and
// on the product output. The FSM runs IDLE -> ACC -> DONE. A new start in DONE
// skips IDLE so products can be issued back to back.
module pp_accum #(
  // Default matches the multiplier datapath width (mul_pkg::WIDTH).
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_PP = WIDTH / 4 + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 pp_valid_i,
  output logic                 pp_ready_o,
  input  logic [WIDTH+2:0]     pp_i,
  input  logic                 pp_neg_i,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic                 prod_valid_o,
  input  logic                 prod_ready_i,
  output logic                 busy_o
);

  localparam int unsigned AccW  = 2 * WIDTH;
  localparam int unsigned PpW   = WIDTH + 3;
  localparam int unsigned FillW = AccW - PpW;
  localparam int unsigned KW    = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam logic [KW-1:0] KLast = KW'(NUM_PP - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [KW-1:0]     k_q, k_d;

  logic              hs;
  logic              clear;
  logic              pp_fill;
  logic [AccW-1:0]   pp_ext;
  logic [AccW-1:0]   pp_shifted;

  // A partial product is taken only while the FSM is in ACC.
  assign hs = pp_valid_i & pp_ready_o;

  // A new product begins from IDLE, or from DONE when the current product is taken.
  assign clear = start_i & ((state_q == StIdle) | ((state_q == StDone) & prod_ready_i));

  // Negative partial products arrive as WIDTH+3-bit two's complement, and their
  // MSB alone cannot show the sign: +8A may have its MSB set. The sign comes from
  // pp_neg_i. A negated zero must still extend as zero.
  assign pp_fill    = pp_neg_i & (|pp_i);
  assign pp_ext     = {{FillW{pp_fill}}, pp_i};
  assign pp_shifted = pp_ext << {k_q, 2'b00};

  // State, accumulator and digit index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StAcc;
      end
      StAcc: begin
        if (hs && (k_q == KLast)) state_d = StDone;
      end
      StDone: begin
        if (prod_ready_i) state_d = start_i ? StAcc : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator and digit index update: clear on a new product, add on a handshake.
  always_comb begin
    acc_d = acc_q;
    k_d   = k_q;
    if (clear) begin
      acc_d = '0;
      k_d   = '0;
    end else if (hs) begin
      acc_d = acc_q + pp_shifted;
      k_d   = k_q + 1'b1;
    end
  end

  // Handshake and status outputs decode the state register only.
  always_comb begin
    pp_ready_o   = 1'b0;
    prod_valid_o = 1'b0;
    busy_o       = 1'b1;
    unique case (state_q)
      StIdle:  busy_o       = 1'b0;
      StAcc:   pp_ready_o   = 1'b1;
      StDone:  prod_valid_o = 1'b1;
      default: busy_o       = 1'b0;
    endcase
  end

  assign prod_o = acc_q;

  // A presented product must hold steady until the consumer takes it.
  a_prod_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDone && !prod_ready_i) |=> (prod_valid_o && $stable(prod_o)));

  // No accumulation may happen outside ACC.
  a_no_acc_outside : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StAcc && !clear) |=> $stable(prod_o));

endmodule
